// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: stall, flush and PC-redirect control
// for load-use hazards, taken jumps and halt requests.
module fetch_sequencer #(
   parameter int ADDR_W          = 16,
   parameter int FLUSH_CYCLES    = 2,
   parameter int LD_STALL_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ins_id,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_rd,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt_req,
   input  logic              resume,
   output logic              stall,
   output logic              stall_pm,
   output logic              pc_mux_sel,
   output logic [ADDR_W-1:0] jmp_loc,
   output logic              flush,
   output logic              ins_valid,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      RUN    = 3'd1,
      LSTALL = 3'd2,
      JFLUSH = 3'd3,
      HALT   = 3'd4
   } state_e;

   localparam logic [2:0] FL_CNT = 3'(FLUSH_CYCLES);
   localparam logic [2:0] LD_CNT = 3'(LD_STALL_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] cnt_dec;
   logic [4:0] rs, rt;
   logic       hazard;
   logic       jmp_take;
   logic       unused_ins;

   assign rs         = ins_id[25:21];
   assign rt         = ins_id[20:16];
   assign unused_ins = ^{ins_id[31:26], ins_id[15:0]};

   assign hazard = ex_is_load & (ex_rd != 5'd0)
                 & ((ex_rd == rs) | (ex_rd == rt));

   // Jumps are honoured in RUN and also abort an ongoing load stall.
   assign jmp_take = jump_req & ((state_q == RUN) | (state_q == LSTALL));
   assign cnt_dec  = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stall      = 1'b0;
      stall_pm   = 1'b0;
      pc_mux_sel = 1'b0;
      jmp_loc    = '0;
      flush      = 1'b0;
      if (jmp_take) begin
         pc_mux_sel = 1'b1;
         jmp_loc    = jump_target;
         flush      = 1'b1;
         cnt_d      = FL_CNT;
         state_d    = (FLUSH_CYCLES > 1) ? JFLUSH : RUN;
      end else begin
         unique case (state_q)
            BOOT: begin
               flush   = 1'b1;
               state_d = RUN;
            end
            RUN: begin
               if (halt_req) begin
                  stall    = 1'b1;
                  stall_pm = 1'b1;
                  flush    = 1'b1;
                  state_d  = HALT;
               end else if (hazard) begin
                  stall    = 1'b1;
                  stall_pm = 1'b1;
                  flush    = 1'b1;
                  cnt_d    = LD_CNT;
                  state_d  = (LD_CNT != 3'd0) ? LSTALL : RUN;
               end
            end
            LSTALL: begin
               stall    = 1'b1;
               stall_pm = 1'b1;
               flush    = 1'b1;
               cnt_d    = cnt_dec;
               if (cnt_q <= 3'd1) state_d = RUN;
            end
            JFLUSH: begin
               flush = 1'b1;
               cnt_d = cnt_dec;
               // The jump cycle itself was the first bubble.
               if (cnt_q <= 3'd2) state_d = RUN;
            end
            HALT: begin
               stall    = 1'b1;
               stall_pm = 1'b1;
               flush    = 1'b1;
               if (resume) state_d = RUN;
            end
            default: begin
               flush   = 1'b1;
               state_d = BOOT;
            end
         endcase
      end
   end

   assign ins_valid = (state_q == RUN) & ~flush;
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: two parameterisations driven
// with directed then random stimulus against a cycle-level model.
module tb_fetch_sequencer;

   typedef struct packed {
      logic        stall;
      logic        stall_pm;
      logic        pc_mux_sel;
      logic [15:0] jmp_loc;
      logic        flush;
      logic        ins_valid;
      logic [2:0]  fsm_state;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ins_id = '0;
   logic        ex_is_load = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic        jump_req = 1'b0;
   logic [15:0] jump_target = '0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;

   logic        st0, sp0, pc0, fl0, iv0;
   logic [15:0] jl0;
   logic [2:0]  fs0;
   logic        st1, sp1, pc1, fl1, iv1;
   logic [15:0] jl1;
   logic [2:0]  fs1;

   exp_t got [2];
   exp_t q0 [$];
   exp_t q1 [$];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // model: 0 BOOT, 1 RUN, 2 load stall, 3 jump flush, 4 halted
   int mst   [2] = '{0, 0};
   int mleft [2] = '{0, 0};
   int ldc   [2] = '{1, 3};
   int flc   [2] = '{2, 3};

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(16), .FLUSH_CYCLES(2), .LD_STALL_CYCLES(1)) dut0 (
      .clk(clk), .reset(reset), .ins_id(ins_id), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .jump_req(jump_req), .jump_target(jump_target),
      .halt_req(halt_req), .resume(resume), .stall(st0), .stall_pm(sp0),
      .pc_mux_sel(pc0), .jmp_loc(jl0), .flush(fl0), .ins_valid(iv0),
      .fsm_state(fs0)
   );

   fetch_sequencer #(.ADDR_W(16), .FLUSH_CYCLES(3), .LD_STALL_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .ins_id(ins_id), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .jump_req(jump_req), .jump_target(jump_target),
      .halt_req(halt_req), .resume(resume), .stall(st1), .stall_pm(sp1),
      .pc_mux_sel(pc1), .jmp_loc(jl1), .flush(fl1), .ins_valid(iv1),
      .fsm_state(fs1)
   );

   assign got[0] = {st0, sp0, pc0, jl0, fl0, iv0, fs0};
   assign got[1] = {st1, sp1, pc1, jl1, fl1, iv1, fs1};

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
      return {6'h23, rs, rt, 16'h0000};
   endfunction

   task automatic model(input int k, input logic rst, input logic [31:0] ins,
                        input logic ld, input logic [4:0] rd, input logic j,
                        input logic [15:0] tgt, input logic h, input logic r,
                        output exp_t e);
      logic hz;
      hz = ld && (rd != 0) && (rd == ins[25:21] || rd == ins[20:16]);
      e = '0;
      if (!rst) begin
         e.flush = 1'b1;
         mst[k] = 0;
         mleft[k] = 0;
         return;
      end
      e.fsm_state = 3'(mst[k]);
      if (j && (mst[k] == 1 || mst[k] == 2)) begin
         e.pc_mux_sel = 1'b1;
         e.jmp_loc = tgt;
         e.flush = 1'b1;
         mleft[k] = flc[k] - 1;
         mst[k] = (mleft[k] > 0) ? 3 : 1;
         return;
      end
      case (mst[k])
         0: begin
            e.flush = 1'b1;
            mst[k] = 1;
         end
         1: begin
            if (h) begin
               e.stall = 1'b1; e.stall_pm = 1'b1; e.flush = 1'b1;
               mst[k] = 4;
            end else if (hz) begin
               e.stall = 1'b1; e.stall_pm = 1'b1; e.flush = 1'b1;
               mleft[k] = ldc[k] - 1;
               mst[k] = (mleft[k] > 0) ? 2 : 1;
            end else begin
               e.ins_valid = 1'b1;
            end
         end
         2: begin
            e.stall = 1'b1; e.stall_pm = 1'b1; e.flush = 1'b1;
            mleft[k] = mleft[k] - 1;
            if (mleft[k] == 0) mst[k] = 1;
         end
         3: begin
            e.flush = 1'b1;
            mleft[k] = mleft[k] - 1;
            if (mleft[k] == 0) mst[k] = 1;
         end
         default: begin
            e.stall = 1'b1; e.stall_pm = 1'b1; e.flush = 1'b1;
            if (r) mst[k] = 1;
         end
      endcase
   endtask

   task automatic step(input logic rst, input logic [31:0] ins, input logic ld,
                       input logic [4:0] rd, input logic j, input logic [15:0] tgt,
                       input logic h, input logic r);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; ins_id = ins; ex_is_load = ld; ex_rd = rd;
      jump_req = j; jump_target = tgt; halt_req = h; resume = r;
      model(0, rst, ins, ld, rd, j, tgt, h, r, e);
      q0.push_back(e);
      model(1, rst, ins, ld, rd, j, tgt, h, r, e);
      q1.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic rand_step();
      logic [4:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd5; regs[2] = 5'd7; regs[3] = 5'd9;
      step($urandom_range(0, 79) != 0,
           mk(regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]),
           1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)],
           $urandom_range(0, 5) == 0, 16'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         checks++;
         if (got[0] !== e) begin
            errors++;
            $display("FAIL dut0 cyc=%0d got=%h exp=%h", cyc, got[0], e);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         checks++;
         if (got[1] !== e) begin
            errors++;
            $display("FAIL dut1 cyc=%0d got=%h exp=%h", cyc, got[1], e);
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, '0, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, mk(5'd5, 5'd1), 1'b1, 5'd5, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(4);
      step(1'b1, mk(5'd0, 5'd1), 1'b1, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2);
      step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b1, 16'h0040, 1'b0, 1'b0);
      idle(4);
      step(1'b1, mk(5'd5, 5'd1), 1'b1, 5'd5, 1'b1, 16'h0abc, 1'b1, 1'b0);
      idle(4);
      step(1'b1, mk(5'd1, 5'd7), 1'b1, 5'd7, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b1, 16'h1234, 1'b0, 1'b0);
      idle(4);
      step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'(i % 2), 16'h5555, 1'b0, 1'b0);
      step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1);
      idle(3);
      step(1'b1, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b1, 16'h0f0f, 1'b0, 1'b0);
      step(1'b0, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, mk(5'd3, 5'd4), 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3);
      for (int i = 0; i < 800; i++) rand_step();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
